// File: rtl/irq_controller.sv
// Interrupt source for the control unit's irq/pcsel handshake: synchronises and edge-detects
// external lines, holds them pending, masks and prioritises them, and tracks the trap in service.
module irq_controller #(
  parameter int N_SRC       = 8,
  parameter int ID_W        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic [2:0]       pcsel,
  input  logic             kernel_mode,
  output logic             irq,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask,
  output logic             in_service
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state_reg, state_next;
  logic [N_SRC-1:0] sync_reg [SYNC_STAGES];
  logic [N_SRC-1:0] sync_prev_reg;
  logic [N_SRC-1:0] pending_reg, pending_next;
  logic [N_SRC-1:0] mask_reg;
  logic [N_SRC-1:0] rise, eligible, clr;
  logic [ID_W-1:0]  sel, irq_id_reg;
  logic             in_service_reg;
  logic             ack;

  // Synchroniser chain plus one extra flop to detect rising edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_reg[i] <= '0;
      sync_prev_reg <= '0;
    end else begin
      sync_reg[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
      sync_prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign rise     = sync_reg[SYNC_STAGES-1] & ~sync_prev_reg;
  assign eligible = pending_reg & mask_reg;

  // Fixed priority: lowest set index wins.
  always_comb begin
    sel = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) sel = ID_W'(i);
    end
  end

  assign irq          = (state_reg == REQ);
  assign ack          = (state_reg == REQ) && irq && (pcsel == 3'd4);
  assign clr          = ack ? (N_SRC'(1) << sel) : '0;
  // A new edge on the bit being acknowledged survives the clear.
  assign pending_next = (pending_reg & ~clr) | rise;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if ((eligible != '0) && !kernel_mode) state_next = REQ;
      REQ: begin
        if (ack)                                        state_next = SERVICE;
        else if ((eligible == '0) || kernel_mode)       state_next = IDLE;
      end
      SERVICE: if (!kernel_mode) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      mask_reg       <= '0;
      irq_id_reg     <= '0;
      in_service_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (mask_we) mask_reg <= mask_wdata;
      if (ack) begin
        irq_id_reg     <= sel;
        in_service_reg <= 1'b1;
      end else if ((state_reg == SERVICE) && !kernel_mode) begin
        in_service_reg <= 1'b0;
      end
    end
  end

  assign irq_id     = irq_id_reg;
  assign pending    = pending_reg;
  assign mask       = mask_reg;
  assign in_service = in_service_reg;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: latency, priority, masking, ack/rise collision and
// reset in the middle of a trap, each against hand-computed values.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] src;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [2:0] pcsel;
  logic       kernel_mode;
  logic       irq;
  logic [2:0] irq_id;
  logic [7:0] pending;
  logic [7:0] mask;
  logic       in_service;

  int checks = 0;
  int errors = 0;

  irq_controller #(.N_SRC(8), .ID_W(3), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .pcsel      (pcsel),
    .kernel_mode(kernel_mode),
    .irq        (irq),
    .irq_id     (irq_id),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick(1);
    mask_we    = 1'b0;
  endtask

  // One-cycle src pulse, then run to the edge after which irq should be up.
  task automatic pulse_to_irq(input logic [7:0] s);
    src = s;
    tick(1);
    src = '0;
    tick(3);
  endtask

  // Trap taken for one cycle; the handler then runs in kernel mode.
  task automatic take_trap(input string tag, input logic [2:0] exp_id, input logic [7:0] exp_pend);
    pcsel = 3'd4;
    tick(1);
    pcsel       = 3'd0;
    kernel_mode = 1'b1;
    check({tag, "_id"},      32'(irq_id),     32'(exp_id));
    check({tag, "_pend"},    32'(pending),    32'(exp_pend));
    check({tag, "_insvc"},   32'(in_service), 1);
    check({tag, "_irq_low"}, 32'(irq),        0);
    $display("ack %s irq_id=%0d pending=%02h", tag, irq_id, pending);
  endtask

  task automatic handler_exit(input string tag);
    tick(1);
    check({tag, "_svc_hold"}, 32'(in_service), 1);
    kernel_mode = 1'b0;
    tick(1);
    check({tag, "_svc_done"}, 32'(in_service), 0);
    check({tag, "_idle_irq"}, 32'(irq),        0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "simulation time limit exceeded");
  end

  initial begin
    reset = 1'b1; src = '0; mask_we = 1'b0; mask_wdata = '0; pcsel = '0; kernel_mode = 1'b0;
    #12;
    check("rst_irq",   32'(irq),        0);
    check("rst_id",    32'(irq_id),     0);
    check("rst_pend",  32'(pending),    0);
    check("rst_mask",  32'(mask),       0);
    check("rst_insvc", 32'(in_service), 0);
    reset = 1'b0;
    $display("reset released");

    // 1: single source, latency
    write_mask(8'hFF);
    check("t1_mask", 32'(mask), 32'hFF);
    src = 8'h20;
    tick(1);
    src = '0;
    check("t1_e0_irq", 32'(irq), 0);
    tick(1);
    check("t1_e1_pend", 32'(pending), 0);
    tick(1);
    check("t1_e2_pend", 32'(pending), 32'h20);
    check("t1_e2_irq",  32'(irq),     0);
    tick(1);
    check("t1_e3_irq",  32'(irq),     1);
    take_trap("t1", 3'd5, 8'h00);
    handler_exit("t1");

    // 2: two sources same cycle, priority order
    pulse_to_irq(8'h44);
    check("t2_pend", 32'(pending), 32'h44);
    check("t2_irq",  32'(irq),     1);
    take_trap("t2a", 3'd2, 8'h40);
    handler_exit("t2a");
    tick(1);
    check("t2_irq2", 32'(irq), 1);
    take_trap("t2b", 3'd6, 8'h00);
    handler_exit("t2b");

    // 3: masked source stays pending, then unmask
    write_mask(8'h00);
    pulse_to_irq(8'h08);
    check("t3_pend",   32'(pending), 32'h08);
    check("t3_masked", 32'(irq),     0);
    write_mask(8'h08);
    check("t3_wr_irq", 32'(irq), 0);
    tick(1);
    check("t3_irq",    32'(irq), 1);
    take_trap("t3", 3'd3, 8'h00);
    handler_exit("t3");

    // 4: request withdrawn by mask, blocked by kernel mode
    write_mask(8'hFF);
    pulse_to_irq(8'h10);
    check("t4_irq", 32'(irq), 1);
    write_mask(8'h00);
    check("t4_w_irq", 32'(irq), 1);
    tick(1);
    check("t4_withdrawn", 32'(irq),     0);
    check("t4_pend",      32'(pending), 32'h10);
    kernel_mode = 1'b1;
    write_mask(8'hFF);
    tick(1);
    check("t4_kernel_irq", 32'(irq), 0);
    kernel_mode = 1'b0;
    tick(1);
    check("t4_user_irq", 32'(irq), 1);
    take_trap("t4", 3'd4, 8'h00);
    handler_exit("t4");

    // 5: new rise on the ack edge of the same index survives
    pulse_to_irq(8'h02);
    check("t5_irq", 32'(irq), 1);
    src = 8'h02;
    tick(2);
    take_trap("t5a", 3'd1, 8'h02);
    src = '0;
    handler_exit("t5a");
    tick(1);
    check("t5_irq2", 32'(irq), 1);
    take_trap("t5b", 3'd1, 8'h00);
    handler_exit("t5b");

    // 6: reset in the middle of service
    pulse_to_irq(8'h04);
    take_trap("t6", 3'd2, 8'h00);
    pulse_to_irq(8'h81);
    check("t6_pend",  32'(pending),    32'h81);
    check("t6_insvc", 32'(in_service), 1);
    reset = 1'b1;
    #1;
    check("t6_rst_irq",   32'(irq),        0);
    check("t6_rst_id",    32'(irq_id),     0);
    check("t6_rst_pend",  32'(pending),    0);
    check("t6_rst_mask",  32'(mask),       0);
    check("t6_rst_insvc", 32'(in_service), 0);
    #2;
    reset       = 1'b0;
    kernel_mode = 1'b0;
    write_mask(8'hFF);
    tick(4);
    check("t6_post_irq",  32'(irq),     0);
    check("t6_post_pend", 32'(pending), 0);
    $display("reset mid-service done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
